// File: rtl/wb_host_mailbox_pkg.sv
// wb_host_mailbox_pkg: shared constants for the host/LM32 mailbox.
// Host offset map helpers, intr status bit position and synchronizer depth.
package wb_host_mailbox_pkg;
  localparam int SYNC_STAGES = 2;
  localparam int INTR_BIT = 8;
  function automatic int db_ofs(input int depth);
    return depth * 4;
  endfunction
  function automatic int hirq_ofs(input int depth);
    return depth * 4 + 1;
  endfunction
endpackage

// File: rtl/wb_host_mailbox_host_bus_sync.sv
// host_bus_sync: synchronizes the async host SRAM bus and derives select, read enable and write commit.
// Ports: clk, rst (async active-low); raw host addr/data/nwe/noe/ncs in;
// ofs (synced offset), hsel, rd_en, commit (one-cycle strobe), cap_ofs/cap_dat (captured write) out.
module host_bus_sync
  import wb_host_mailbox_pkg::*;
#(
  parameter logic [6:0] host_base = 7'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [12:0] addr,
  input  logic [7:0]  data,
  input  logic        nwe,
  input  logic        noe,
  input  logic        ncs,
  output logic [5:0]  ofs,
  output logic        hsel,
  output logic        rd_en,
  output logic        commit,
  output logic [5:0]  cap_ofs,
  output logic [7:0]  cap_dat
);
  // Bundle layout: {addr[12:0], data[7:0], nwe, noe, ncs}; strobes idle high.
  localparam logic [23:0] IDLE = 24'h000007;
  logic [SYNC_STAGES-1:0][23:0] q;
  logic [23:0] s2;
  logic nwe_d, cap_valid;
  assign s2 = q[SYNC_STAGES-1];
  assign ofs = s2[16:11];
  assign hsel = !s2[0] && s2[23:17] == host_base;
  assign rd_en = hsel && !s2[1];
  // cap_valid keeps a rising nwe without a selected low phase (or one lost to reset) from committing.
  assign commit = s2[2] && !nwe_d && cap_valid;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= {SYNC_STAGES{IDLE}};
      nwe_d <= 1'b1;
      cap_valid <= 1'b0;
      cap_ofs <= '0;
      cap_dat <= '0;
    end else begin
      q <= {q[SYNC_STAGES-2:0], {addr, data, nwe, noe, ncs}};
      nwe_d <= s2[2];
      if (hsel && !s2[2]) begin
        cap_ofs <= s2[16:11];
        cap_dat <= s2[10:3];
        cap_valid <= 1'b1;
      end else if (commit) cap_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/wb_host_mailbox.sv
// wb_host_mailbox: Wishbone slave sharing a byte mailbox with an async SRAM-style host bus, with doorbells.
// Ports: clk, rst (async active-low); Wishbone slave wb_*; intr (host doorbell to LM32);
// host_irq (LM32 doorbell to host); host bus addr/sram_data_i/sram_data_o/sram_data_oe/nwe/noe/ncs.
// Optional: define WB_HOST_MAILBOX_HOST_IRQ_EN to enable the LM32-to-host doorbell (word depth+1, offset B+1).
module wb_host_mailbox
  import wb_host_mailbox_pkg::*;
#(
  parameter int         depth     = 16,
  parameter logic [6:0] host_base = 7'h00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_we_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_ack_o,
  output logic        intr,
  output logic        host_irq,
  input  logic [12:0] addr,
  input  logic [7:0]  sram_data_i,
  output logic [7:0]  sram_data_o,
  output logic        sram_data_oe,
  input  logic        nwe,
  input  logic        noe,
  input  logic        ncs
);
  localparam int NB = depth * 4;
  localparam int DB = db_ofs(depth);
  localparam int HI = hirq_ofs(depth);
  logic [5:0] ofs, cap_ofs;
  logic [7:0] cap_dat, db_byte, hbyte;
  logic hsel, rd_en, commit, wb_hit, wb_wr, db_set, db_clr;
  logic [31:0] wrd;
  logic [7:0] mem [NB];
  logic [3:0][7:0] wbytes;
  int widx, hofs, cofs;
  logic unused;
  assign unused = ^{wb_adr_i[31:10], wb_adr_i[1:0], hsel};
  host_bus_sync #(.host_base(host_base)) u_sync (
    .clk(clk), .rst(rst), .addr(addr), .data(sram_data_i), .nwe(nwe), .noe(noe), .ncs(ncs),
    .ofs(ofs), .hsel(hsel), .rd_en(rd_en), .commit(commit), .cap_ofs(cap_ofs), .cap_dat(cap_dat)
  );
  assign widx = int'(wb_adr_i[9:2]);
  assign hofs = int'(ofs);
  assign cofs = int'(cap_ofs);
  assign wbytes = wb_dat_i;
  assign wb_hit = wb_stb_i && wb_cyc_i && !wb_ack_o;
  assign wb_wr = wb_hit && wb_we_i;
  assign db_set = commit && cofs == DB;
  assign db_clr = wb_wr && widx == depth && wb_sel_i[0] && wb_dat_i[0];
  always_comb begin
    hbyte = '0;
    for (int i = 0; i < NB; i++) if (hofs == i) hbyte = mem[i];
    if (hofs == DB) hbyte = {7'b0, intr};
`ifdef WB_HOST_MAILBOX_HOST_IRQ_EN
    if (hofs == HI) hbyte = {7'b0, host_irq};
`endif
  end
  always_comb begin
    wrd = '0;
    for (int i = 0; i < depth; i++) if (widx == i) wrd = {mem[4*i+3], mem[4*i+2], mem[4*i+1], mem[4*i]};
    if (widx == depth) begin
      wrd[7:0] = db_byte;
      wrd[INTR_BIT] = intr;
    end
`ifdef WB_HOST_MAILBOX_HOST_IRQ_EN
    if (widx == depth + 1) wrd = {31'b0, host_irq};
`endif
  end
  // Host commit is applied after the WB write so it wins a same-byte collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (wb_wr && widx == i / 4 && wb_sel_i[2'(i)]) mem[i] <= wbytes[2'(i)];
        if (commit && cofs == i) mem[i] <= cap_dat;
      end
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
      intr <= 1'b0;
      db_byte <= '0;
      sram_data_o <= '0;
      sram_data_oe <= 1'b0;
    end else begin
      wb_ack_o <= wb_hit;
      if (wb_hit) wb_dat_o <= wrd;
      intr <= db_set || (intr && !db_clr);
      if (db_set) db_byte <= cap_dat;
      sram_data_oe <= rd_en;
      if (rd_en) sram_data_o <= hbyte;
    end
  end
`ifdef WB_HOST_MAILBOX_HOST_IRQ_EN
  logic hirq_set, hirq_clr;
  assign hirq_set = wb_wr && widx == depth + 1 && wb_sel_i[0] && wb_dat_i[0];
  assign hirq_clr = commit && cofs == HI;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) host_irq <= 1'b0;
    else host_irq <= !hirq_clr && (hirq_set || host_irq);
  end
`else
  assign host_irq = 1'b0;
`endif
endmodule

// File: tb/tb_wb_host_mailbox.sv
// tb_wb_host_mailbox: directed self-checking bench for wb_host_mailbox (depth 8 so the doorbell offset fits addr[5:0]).
module tb_wb_host_mailbox;
  localparam int DEPTH = 8;
  localparam logic [6:0] BASE = 7'h05;
  localparam logic [5:0] B = 6'(DEPTH * 4);
  logic clk = 0, rst = 0;
  logic [31:0] wb_adr_i = 0, wb_dat_i = 0, wb_dat_o;
  logic [3:0] wb_sel_i = 0;
  logic wb_we_i = 0, wb_stb_i = 0, wb_cyc_i = 0, wb_ack_o, intr, host_irq;
  logic [12:0] addr = 0;
  logic [7:0] sram_data_i = 0, sram_data_o;
  logic sram_data_oe, nwe = 1, noe = 1, ncs = 1;
  int pass_cnt = 0, total = 0;

  always #5 clk = ~clk;

  wb_host_mailbox #(.depth(DEPTH), .host_base(BASE)) dut (
    .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_ack_o(wb_ack_o), .intr(intr), .host_irq(host_irq), .addr(addr),
    .sram_data_i(sram_data_i), .sram_data_o(sram_data_o), .sram_data_oe(sram_data_oe),
    .nwe(nwe), .noe(noe), .ncs(ncs)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task host_write(input logic [5:0] o, input logic [7:0] d);
    addr = {BASE, o}; sram_data_i = d; ncs = 0; nwe = 0;
    repeat (4) tick;
    nwe = 1;
    repeat (4) tick;
    ncs = 1;
    tick;
  endtask

  task host_read(input logic [5:0] o, output logic [7:0] d, output logic oe);
    addr = {BASE, o}; ncs = 0; noe = 0;
    repeat (3) tick;
    d = sram_data_o; oe = sram_data_oe;
    tick;
    noe = 1; ncs = 1;
    repeat (3) tick;
  endtask

  // Holds stb across two edges so a second (back-to-back) ack would be seen in a2.
  task wb_xfer(input logic we, input int word, input logic [31:0] d, input logic [3:0] s,
               output logic [31:0] r, output logic a0, output logic a1, output logic a2);
    wb_adr_i = 32'(word) << 2; wb_dat_i = d; wb_sel_i = s; wb_we_i = we; wb_stb_i = 1; wb_cyc_i = 1;
    a0 = wb_ack_o;
    tick;
    a1 = wb_ack_o; r = wb_dat_o;
    tick;
    a2 = wb_ack_o;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    tick;
  endtask

  // Host commit and WB write land on the same clock edge.
  task collide(input logic [5:0] o, input logic [7:0] hd, input int word, input logic [31:0] wd, input logic [3:0] ws);
    addr = {BASE, o}; sram_data_i = hd; ncs = 0; nwe = 0;
    repeat (4) tick;
    nwe = 1;
    tick;
    tick;
    wb_adr_i = 32'(word) << 2; wb_dat_i = wd; wb_sel_i = ws; wb_we_i = 1; wb_stb_i = 1; wb_cyc_i = 1;
    tick;
    wb_stb_i = 0; wb_cyc_i = 0; wb_we_i = 0;
    tick;
    ncs = 1;
    tick;
  endtask

  task test_reset;
    logic [31:0] r; logic a0, a1, a2; logic [7:0] d; logic oe;
    host_write(B, 8'h01);
    total++; if (intr !== 1'b1) $display("FAIL pre_intr: got %b want 1", intr); else pass_cnt++;
    wb_xfer(0, DEPTH, 0, 4'hF, r, a0, a1, a2);
    addr = {BASE, 6'd0}; sram_data_i = 8'hFF; ncs = 0; nwe = 0;
    repeat (3) tick;
    rst = 0;
    #1;
    total++;
    if ({wb_ack_o, wb_dat_o, intr, host_irq, sram_data_o, sram_data_oe} !== 44'h0)
      $display("FAIL rst_outputs: got ack=%b dat=%h intr=%b hirq=%b sd=%h oe=%b want all 0", wb_ack_o, wb_dat_o, intr, host_irq, sram_data_o, sram_data_oe);
    else pass_cnt++;
    tick;
    nwe = 1; ncs = 1;
    repeat (2) tick;
    rst = 1;
    repeat (3) tick;
    host_read(6'd0, d, oe);
    total++; if (d !== 8'h00) $display("FAIL rst_read_data: got %h want 00", d); else pass_cnt++;
    total++; if (oe !== 1'b1) $display("FAIL rst_read_oe: got %b want 1", oe); else pass_cnt++;
    total++; if (intr !== 1'b0) $display("FAIL rst_intr: got %b want 0", intr); else pass_cnt++;
  endtask

  task test_host_write;
    logic [31:0] r; logic a0, a1, a2;
    host_write(6'd5, 8'hA5);
    wb_xfer(0, 1, 0, 4'hF, r, a0, a1, a2);
    total++; if (r !== 32'h0000A500) $display("FAIL hw_word1: got %h want 0000a500", r); else pass_cnt++;
    total++; if (a0 !== 1'b0) $display("FAIL hw_ack_early: got %b want 0", a0); else pass_cnt++;
    total++; if (a1 !== 1'b1) $display("FAIL hw_ack: got %b want 1", a1); else pass_cnt++;
    total++; if (a2 !== 1'b0) $display("FAIL hw_ack_b2b: got %b want 0", a2); else pass_cnt++;
  endtask

  task test_wb_sel;
    logic [31:0] r; logic a0, a1, a2; logic [7:0] d; logic oe;
    logic [7:0] exp [4];
    exp = '{8'h44, 8'h00, 8'h22, 8'h00};
    wb_xfer(1, 2, 32'h11223344, 4'b0101, r, a0, a1, a2);
    for (int i = 0; i < 4; i++) begin
      host_read(6'(8 + i), d, oe);
      total++; if (d !== exp[i]) $display("FAIL sel_byte%0d: got %h want %h", 8 + i, d, exp[i]); else pass_cnt++;
    end
  endtask

  task test_doorbell;
    logic [31:0] r; logic a0, a1, a2; logic [7:0] d; logic oe;
    host_write(B, 8'h7E);
    total++; if (intr !== 1'b1) $display("FAIL db_intr_set: got %b want 1", intr); else pass_cnt++;
    wb_xfer(0, DEPTH, 0, 4'hF, r, a0, a1, a2);
    total++; if (r !== 32'h0000017E) $display("FAIL db_status: got %h want 0000017e", r); else pass_cnt++;
    wb_xfer(1, DEPTH, 32'h1, 4'b0001, r, a0, a1, a2);
    total++; if (intr !== 1'b0) $display("FAIL db_intr_clr: got %b want 0", intr); else pass_cnt++;
    host_read(B, d, oe);
    total++; if (d !== 8'h00) $display("FAIL db_host_read: got %h want 00", d); else pass_cnt++;
    collide(B, 8'h3C, DEPTH, 32'h1, 4'b0001);
    total++; if (intr !== 1'b1) $display("FAIL db_set_wins: got %b want 1", intr); else pass_cnt++;
    wb_xfer(0, DEPTH, 0, 4'hF, r, a0, a1, a2);
    total++; if (r !== 32'h0000013C) $display("FAIL db_status2: got %h want 0000013c", r); else pass_cnt++;
  endtask

  task test_collision;
    logic [7:0] d; logic oe;
    collide(6'd0, 8'h55, 0, 32'h000000AA, 4'b0001);
    host_read(6'd0, d, oe);
    total++; if (d !== 8'h55) $display("FAIL coll_byte0: got %h want 55", d); else pass_cnt++;
  endtask

  task test_out_of_range;
    logic [31:0] r; logic a0, a1, a2; logic [7:0] d; logic oe;
    wb_xfer(1, 20, 32'hFFFFFFFF, 4'hF, r, a0, a1, a2);
    wb_xfer(0, 20, 0, 4'hF, r, a0, a1, a2);
    total++; if (r !== 32'h0) $display("FAIL oor_wb_data: got %h want 0", r); else pass_cnt++;
    total++; if (a1 !== 1'b1) $display("FAIL oor_wb_ack: got %b want 1", a1); else pass_cnt++;
    host_read(6'd40, d, oe);
    total++; if (d !== 8'h00) $display("FAIL oor_host_data: got %h want 00", d); else pass_cnt++;
    total++; if (oe !== 1'b1) $display("FAIL oor_host_oe: got %b want 1", oe); else pass_cnt++;
  endtask

  task test_host_irq;
    logic [31:0] r; logic a0, a1, a2; logic [7:0] d; logic oe;
    wb_xfer(1, DEPTH + 1, 32'h1, 4'b0001, r, a0, a1, a2);
`ifdef WB_HOST_MAILBOX_HOST_IRQ_EN
    total++; if (host_irq !== 1'b1) $display("FAIL hirq_set: got %b want 1", host_irq); else pass_cnt++;
    wb_xfer(0, DEPTH + 1, 0, 4'hF, r, a0, a1, a2);
    total++; if (r !== 32'h1) $display("FAIL hirq_wb_read: got %h want 1", r); else pass_cnt++;
    host_read(B + 6'd1, d, oe);
    total++; if (d !== 8'h01) $display("FAIL hirq_host_read: got %h want 01", d); else pass_cnt++;
    addr = {BASE, B + 6'd1}; sram_data_i = 8'h00; ncs = 0; nwe = 0;
    repeat (4) tick;
    nwe = 1;
    repeat (3) tick;
    total++; if (host_irq !== 1'b0) $display("FAIL hirq_clr: got %b want 0", host_irq); else pass_cnt++;
    ncs = 1;
    tick;
    wb_xfer(1, DEPTH + 1, 32'h1, 4'b0001, r, a0, a1, a2);
    collide(B + 6'd1, 8'h00, DEPTH + 1, 32'h1, 4'b0001);
    total++; if (host_irq !== 1'b0) $display("FAIL hirq_clr_wins: got %b want 0", host_irq); else pass_cnt++;
`else
    total++; if (host_irq !== 1'b0) $display("FAIL hirq_tied: got %b want 0", host_irq); else pass_cnt++;
    wb_xfer(0, DEPTH + 1, 0, 4'hF, r, a0, a1, a2);
    total++; if (r !== 32'h0) $display("FAIL hirq_wb_read: got %h want 0", r); else pass_cnt++;
    host_read(B + 6'd1, d, oe);
    total++; if (d !== 8'h00) $display("FAIL hirq_host_read: got %h want 00", d); else pass_cnt++;
`endif
  endtask

  initial begin
    repeat (3) tick;
    rst = 1;
    repeat (3) tick;
    test_reset;
    test_host_write;
    test_wb_sel;
    test_doorbell;
    test_collision;
    test_out_of_range;
    test_host_irq;
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
